// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
// Also holds the rotating-priority rank and one-hot helpers.
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
    localparam logic [2:0] PRIO_LOW_RESET = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ACK1  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_VEC   = 3'd4
    } pic_state_e;

    // Rank 0 is the highest priority, i.e. the level just above prio_low.
    function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] prio_low);
        return level - prio_low - 3'd1;
    endfunction

    function automatic logic [NUM_IR-1:0] level_onehot(input logic [2:0] level);
        return 8'b1 << level;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Rotating find-first: returns the highest-priority set bit of vec, where
// the level just above prio_low wins and priority descends cyclically.
import pic_pkg::*;

module priority_resolver (
    input  logic [NUM_IR-1:0] vec,
    input  logic [2:0]        prio_low,
    output logic              valid,
    output logic [2:0]        level
);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        valid = |vec;
        level = SPURIOUS_LEVEL;
        for (int i = NUM_IR; i >= 1; i--) begin
            if (vec[prio_low + 3'(i)]) begin
                level = prio_low + 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_ack_sequencer.sv
// 8259-style interrupt acknowledge sequencer for 8086 two-pulse INTA mode:
// raises INT, runs the INTA handshake, maintains ISR and handles EOI/rotation.
import pic_pkg::*;

module int_ack_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic [7:0]  irr,
    input  logic [7:0]  imr,
    input  logic [4:0]  vector_base,
    input  logic        mode_8086,
    input  logic        auto_eoi,
    input  logic        inta_n,
    input  logic        eoi_valid,
    input  logic        eoi_specific,
    input  logic [2:0]  eoi_level,
    input  logic        eoi_rotate,
    output logic        int_out,
    output logic [7:0]  irr_clr,
    output logic [7:0]  isr,
    output logic [7:0]  vec_out,
    output logic        vec_oe,
    output logic [2:0]  dbg_state
);

    pic_state_e  state_q, state_d;
    logic        inta_q;
    logic [7:0]  isr_q, isr_d;
    logic [2:0]  prio_low_q, prio_low_d;
    logic [2:0]  level_q, level_d;
    logic        spurious_q, spurious_d;
    logic [7:0]  irr_clr_q, irr_clr_d;

    logic [7:0]  pending;
    logic        pend_valid, isr_valid;
    logic [2:0]  best, isr_top;
    logic        outranks, req_ok, enabled;
    logic        inta_fall, inta_rise;
    logic        ack_take, vec_exit;
    logic [7:0]  ack_set, auto_clr, eoi_clr;

    assign pending   = irr & ~imr;
    assign enabled   = init_done & mode_8086;
    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;

    priority_resolver u_pend_res (
        .vec      (pending),
        .prio_low (prio_low_q),
        .valid    (pend_valid),
        .level    (best)
    );

    priority_resolver u_isr_res (
        .vec      (isr_q),
        .prio_low (prio_low_q),
        .valid    (isr_valid),
        .level    (isr_top)
    );

    assign outranks = prio_rank(best, prio_low_q) < prio_rank(isr_top, prio_low_q);
    assign req_ok   = enabled & pend_valid & (~isr_valid | outranks);

    always_comb begin
        state_d  = state_q;
        ack_take = 1'b0;
        vec_exit = 1'b0;
        case (state_q)
            ST_IDLE:  if (req_ok) state_d = ST_REQ;
            ST_REQ: begin
                // An INTA fall takes precedence; it may arrive as pending vanishes.
                if (inta_fall) begin
                    state_d  = ST_ACK1;
                    ack_take = 1'b1;
                end else if (!req_ok) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK1:  if (inta_rise) state_d = ST_WAIT2;
            ST_WAIT2: if (inta_fall) state_d = ST_VEC;
            ST_VEC: begin
                if (inta_rise) begin
                    state_d  = ST_IDLE;
                    vec_exit = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        if (!enabled) begin
            state_d  = ST_IDLE;
            ack_take = 1'b0;
            vec_exit = 1'b0;
        end
    end

    always_comb begin
        level_d    = level_q;
        spurious_d = spurious_q;
        irr_clr_d  = '0;
        ack_set    = '0;
        if (ack_take) begin
            if (pend_valid) begin
                level_d    = best;
                spurious_d = 1'b0;
                ack_set    = level_onehot(best);
                irr_clr_d  = level_onehot(best);
            end else begin
                level_d    = SPURIOUS_LEVEL;
                spurious_d = 1'b1;
            end
        end
    end

    assign auto_clr = (vec_exit && auto_eoi && !spurious_q) ? level_onehot(level_q) : '0;

    always_comb begin
        eoi_clr    = '0;
        prio_low_d = prio_low_q;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_clr = level_onehot(eoi_level);
                if (eoi_rotate) prio_low_d = eoi_level;
            end else if (isr_valid) begin
                eoi_clr = level_onehot(isr_top);
                if (eoi_rotate) prio_low_d = isr_top;
            end
        end
        // Set is ORed in last so an acknowledge beats a same-cycle clear.
        isr_d = (isr_q & ~eoi_clr & ~auto_clr) | ack_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            inta_q     <= 1'b1;
            isr_q      <= '0;
            prio_low_q <= PRIO_LOW_RESET;
            level_q    <= '0;
            spurious_q <= 1'b0;
            irr_clr_q  <= '0;
        end else begin
            state_q    <= state_d;
            inta_q     <= inta_n;
            isr_q      <= isr_d;
            prio_low_q <= prio_low_d;
            level_q    <= level_d;
            spurious_q <= spurious_d;
            irr_clr_q  <= irr_clr_d;
        end
    end

    assign int_out   = (state_q == ST_REQ) && req_ok && !inta_fall;
    assign vec_oe    = (state_q == ST_VEC) && !inta_rise && enabled;
    assign vec_out   = vec_oe ? {vector_base, level_q} : '0;
    assign irr_clr   = irr_clr_q;
    assign isr       = isr_q;
    assign dbg_state = state_q;

endmodule

// File: doc/int_ack_sequencer.md
INT_ACK_SEQUENCER -- requirements
Module: int_ack_sequencer

Interface
REQ-001 clk  input  1  System clock; all state updates on rising edge.
REQ-002 reset  input  1  Asynchronous, active-high reset.
REQ-003 init_done  input  1  High once the ICW sequence completes; low means not initialised.
REQ-004 irr  input  8  Latched interrupt request register, bit n = IRn.
REQ-005 imr  input  8  Interrupt mask (OCW1); bit set masks IRn.
REQ-006 vector_base  input  5  ICW2[7:3], vector bits T7..T3.
REQ-007 mode_8086  input  1  ICW4[0]; 1 = 8086 two-pulse INTA mode.
REQ-008 auto_eoi  input  1  ICW4[1]; 1 = clear ISR bit at end of second INTA.
REQ-009 inta_n  input  1  CPU acknowledge, active-low, synchronous to clk.
REQ-010 eoi_valid  input  1  One-cycle pulse: OCW2 EOI command written.
REQ-011 eoi_specific  input  1  OCW2 SL bit; 1 = specific EOI.
REQ-012 eoi_level  input  3  OCW2 L2..L0, used when eoi_specific = 1.
REQ-013 eoi_rotate  input  1  OCW2 R bit; 1 = rotate priority on this EOI.
REQ-014 int_out  output  1  INT request to CPU.
REQ-015 irr_clr  output  8  One-hot, one-cycle pulse clearing the acknowledged IRR bit.
REQ-016 isr  output  8  In-service register.
REQ-017 vec_out  output  8  Vector byte {vector_base, level}.
REQ-018 vec_oe  output  1  High while vec_out must drive the data bus.

Function
REQ-019 The block SHALL sample inta_n into one register and detect falling/rising edges from the (registered, current) pair.
REQ-020 Priority SHALL be rotating: prio_low (3 bits, reset 7) is the lowest level; highest is (prio_low+1) mod 8, descending cyclically.
REQ-021 pending = irr & ~imr; best = highest-priority set bit of pending; isr_top = highest-priority set bit of isr.
REQ-022 States: IDLE, REQ, ACK1, WAIT2, VEC.
REQ-023 IDLE->REQ when init_done=1, mode_8086=1, pending!=0 and (isr=0 or best outranks isr_top); int_out=1 in REQ only.
REQ-024 REQ->IDLE if pending becomes 0 or no longer outranks isr_top before an inta_n fall (int_out drops same cycle).
REQ-025 REQ->ACK1 on inta_n fall: latch level=best, set isr[level], pulse irr_clr[level] for exactly one cycle, int_out=0.
REQ-026 If pending=0 at that inta_n fall, level SHALL be 7 (spurious), with no isr set and no irr_clr.
REQ-027 ACK1->WAIT2 on inta_n rise; WAIT2->VEC on next inta_n fall.
REQ-028 In VEC, vec_oe=1 and vec_out={vector_base, level}; VEC->IDLE on inta_n rise, vec_oe=0 in that cycle.
REQ-029 On VEC exit with auto_eoi=1 and a non-spurious level, isr[level] SHALL clear; if eoi_rotate... not applicable; prio_low SHALL stay unchanged.
REQ-030 Non-specific EOI clears isr_top; specific EOI clears isr[eoi_level]; EOI with isr=0 (non-specific) has no effect.
REQ-031 When eoi_rotate=1, prio_low SHALL become the cleared level (non-specific: isr_top; specific: eoi_level).
REQ-032 EOI is accepted in every state; if an EOI clear and an ACK set hit the same isr bit in one cycle, set SHALL win.
REQ-033 init_done falling mid-sequence SHALL return the FSM to IDLE next cycle with int_out=0, vec_oe=0; isr is kept.
REQ-034 mode_8086=0 SHALL hold the FSM in IDLE (8080 mode unsupported).

Reset
REQ-035 On reset: state=IDLE, isr=0, prio_low=7, int_out=0, irr_clr=0, vec_out=0, vec_oe=0, inta_n register=1.
REQ-036 Reset asserted mid-acknowledge SHALL abort immediately with no further irr_clr pulse.

Structure
REQ-037 Shared package pic_pkg SHALL hold the state enumeration, NUM_IR=8, and the spurious level constant 7.
REQ-038 Rotating find-first logic SHALL be one sub-module, priority_resolver (inputs vector, prio_low; outputs valid, level), instantiated twice (pending, isr).

Verification
REQ-039 irr=0x05, imr=0, vector_base=0x08, two INTA pulses -> irr_clr=0x01, isr=0x01, vec_out=0x40.
REQ-040 isr=0x04, irr=0x10 -> int_out stays 0; then irr=0x02 -> int_out=1, ack sets isr=0x06, vec level 1.
REQ-041 auto_eoi=1, irr=0x80 ack -> isr=0x80 after first INTA, 0x00 after second INTA rise.
REQ-042 isr=0x08, non-specific rotate EOI -> isr=0, prio_low=3; irr=0x18 -> level 4 acknowledged first.
REQ-043 irr drops to 0 in REQ before INTA -> int_out=0; forced INTA pair -> vec_out={base,3'd7}, isr unchanged.
REQ-044 Reset asserted in WAIT2 -> all outputs at reset values next edge, isr=0.
